// File: rtl/echo_queue_if.sv
// Handshake bundle for echo_queue: request side, indication side and occupancy.
// ECHO_QUEUE_SEQNUM_EN adds the per-indication sequence number to the bundle.
interface echo_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             echoReq__ENA;
    logic [WIDTH-1:0] echoReq_v;
    logic             echoReq__RDY;
    logic             ind_echo__ENA;
    logic [WIDTH-1:0] ind_echo_v;
    logic             ind_echo__RDY;
    logic [CW-1:0]    count;
`ifdef ECHO_QUEUE_SEQNUM_EN
    logic [15:0]      ind_echo_seq;

    modport master (
        output echoReq__ENA, echoReq_v, ind_echo__RDY,
        input  echoReq__RDY, ind_echo__ENA, ind_echo_v, count, ind_echo_seq
    );
    modport slave (
        input  echoReq__ENA, echoReq_v, ind_echo__RDY,
        output echoReq__RDY, ind_echo__ENA, ind_echo_v, count, ind_echo_seq
    );
`else
    modport master (
        output echoReq__ENA, echoReq_v, ind_echo__RDY,
        input  echoReq__RDY, ind_echo__ENA, ind_echo_v, count
    );
    modport slave (
        input  echoReq__ENA, echoReq_v, ind_echo__RDY,
        output echoReq__RDY, ind_echo__ENA, ind_echo_v, count
    );
`endif
endinterface

// File: rtl/echo_queue.sv
// Circular-buffer echo queue: requests are stored and returned in order with OFFSET added.
// Optional feature macro: ECHO_QUEUE_SEQNUM_EN (adds a 16-bit indication sequence number).
module echo_queue #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int OFFSET = 0
) (
    input  logic         CLK,
    input  logic         nRST,
    echo_queue_if.slave  q
);
    localparam int             AW   = $clog2(DEPTH);
    localparam int             CW   = AW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);
    localparam logic [WIDTH-1:0] OFF = WIDTH'(OFFSET);

    function automatic logic [WIDTH-1:0] add_offset(input logic [WIDTH-1:0] x);
        return x + OFF;
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_ind_ena;
    logic w_req_rdy;
    logic w_enq;
    logic w_deq;

    assign w_ind_ena = (r_count != '0);
    // At full, a slot is still offered when the head leaves in the same cycle.
    assign w_req_rdy = !nRST &&
                       ((r_count < FULL) ||
                        ((r_count == FULL) && q.ind_echo__RDY && w_ind_ena));
    assign w_enq     = q.echoReq__ENA && w_req_rdy;
    assign w_deq     = w_ind_ena && q.ind_echo__RDY;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_enq) r_mem[r_wr_ptr] <= q.echoReq_v;
    end

    assign q.echoReq__RDY  = w_req_rdy;
    assign q.ind_echo__ENA = w_ind_ena;
    assign q.ind_echo_v    = add_offset(r_mem[r_rd_ptr]);
    assign q.count         = r_count;

`ifdef ECHO_QUEUE_SEQNUM_EN
    logic [15:0] r_seq;

    always_ff @(posedge CLK) begin
        if (nRST)       r_seq <= '0;
        else if (w_deq) r_seq <= r_seq + 16'd1;
    end

    assign q.ind_echo_seq = r_seq;
`endif
endmodule

// File: tb/tb_echo_queue.sv
// Directed bench for echo_queue: per-cycle vector table plus reset and offset-wrap sequences.
module tb_echo_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    echo_queue_if #(.WIDTH(32), .DEPTH(4)) bus ();
    echo_queue_if #(.WIDTH(8),  .DEPTH(4)) bus8 ();

    echo_queue #(.WIDTH(32), .DEPTH(4), .OFFSET(0)) dut  (.CLK(clk), .nRST(rst), .q(bus));
    echo_queue #(.WIDTH(8),  .DEPTH(4), .OFFSET(3)) dut8 (.CLK(clk), .nRST(rst), .q(bus8));

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned seq_m = 0;

    typedef struct {
        logic        ena;
        logic [31:0] v;
        logic        rdy;
        logic        x_req_rdy;
        logic        x_ind_ena;
        logic [31:0] x_v;
        logic [31:0] x_cnt;
    } vec_t;

    vec_t tv [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ena, input logic [31:0] v, input logic rdy);
        bus.echoReq__ENA  = ena;
        bus.echoReq_v     = v;
        bus.ind_echo__RDY = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        //          ena  v             rdy  x_rdy x_ena x_v           x_cnt
        tv[0]  = '{1'b1, 32'h0000_1234, 1'b1, 1'b1, 1'b0, 32'h0,        0};
        tv[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_1234, 1};
        tv[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,        0};
        tv[3]  = '{1'b1, 32'd1,         1'b0, 1'b1, 1'b0, 32'h0,        0};
        tv[4]  = '{1'b1, 32'd2,         1'b0, 1'b1, 1'b1, 32'd1,        1};
        tv[5]  = '{1'b1, 32'd3,         1'b0, 1'b1, 1'b1, 32'd1,        2};
        tv[6]  = '{1'b1, 32'd4,         1'b0, 1'b1, 1'b1, 32'd1,        3};
        tv[7]  = '{1'b1, 32'd5,         1'b0, 1'b0, 1'b1, 32'd1,        4};
        tv[8]  = '{1'b1, 32'd9,         1'b1, 1'b1, 1'b1, 32'd1,        4};
        tv[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'd2,        4};
        tv[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'd3,        3};
        tv[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'd4,        2};
        tv[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'd9,        1};
        tv[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,        0};
        tv[14] = '{1'b1, 32'hAA,        1'b0, 1'b1, 1'b0, 32'h0,        0};
        tv[15] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hAA,       1};
        tv[16] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hAA,       1};
        tv[17] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hAA,       1};
        tv[18] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,        0};
        tv[19] = '{1'b1, 32'h11,        1'b1, 1'b1, 1'b0, 32'h0,        0};
        tv[20] = '{1'b1, 32'h22,        1'b1, 1'b1, 1'b1, 32'h11,       1};
        tv[21] = '{1'b1, 32'h33,        1'b1, 1'b1, 1'b1, 32'h22,       1};
        tv[22] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h33,       1};
        tv[23] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,        0};

        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        bus8.echoReq__ENA  = 1'b0;
        bus8.echoReq_v     = 8'h0;
        bus8.ind_echo__RDY = 1'b1;

        // Reset behaviour
        cyc();
        @(negedge clk);
        check("rst_req_rdy", 32'(bus.echoReq__RDY), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_ind_ena", 32'(bus.ind_echo__ENA), 32'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_rdy", 32'(bus.echoReq__RDY), 32'd1);
        cyc();

        // Per-cycle vector table
        for (int i = 0; i < 24; i++) begin
            drive(tv[i].ena, tv[i].v, tv[i].rdy);
            @(negedge clk);
            check($sformatf("v%0d_req_rdy", i), 32'(bus.echoReq__RDY), 32'(tv[i].x_req_rdy));
            check($sformatf("v%0d_ind_ena", i), 32'(bus.ind_echo__ENA), 32'(tv[i].x_ind_ena));
            check($sformatf("v%0d_count", i), 32'(bus.count), tv[i].x_cnt);
            if (tv[i].x_ind_ena)
                check($sformatf("v%0d_ind_v", i), bus.ind_echo_v, tv[i].x_v);
`ifdef ECHO_QUEUE_SEQNUM_EN
            if (tv[i].x_ind_ena)
                check($sformatf("v%0d_seq", i), 32'(bus.ind_echo_seq), seq_m);
            if (tv[i].x_ind_ena && tv[i].rdy) seq_m++;
`endif
            cyc();
        end

        // Offset wraps modulo 2^WIDTH on the 8-bit instance
        bus8.echoReq__ENA = 1'b1;
        bus8.echoReq_v    = 8'hFE;
        @(negedge clk);
        check("off_count0", 32'(bus8.count), 32'd0);
        cyc();
        bus8.echoReq_v = 8'h10;
        @(negedge clk);
        check("off_ind_ena", 32'(bus8.ind_echo__ENA), 32'd1);
        check("off_wrap_v", 32'(bus8.ind_echo_v), 32'h01);
        cyc();
        bus8.echoReq__ENA = 1'b0;
        @(negedge clk);
        check("off_plain_v", 32'(bus8.ind_echo_v), 32'h13);
        cyc();

        // Reset mid-stream discards queued entries and the request in the reset cycle
        drive(1'b1, 32'hA1, 1'b0); cyc();
        drive(1'b1, 32'hA2, 1'b0); cyc();
        drive(1'b1, 32'hA3, 1'b0);
        @(negedge clk);
        check("mid_count2", 32'(bus.count), 32'd2);
        cyc();
        rst = 1'b1;
        drive(1'b1, 32'hEE, 1'b0);
        @(negedge clk);
        check("mid_count3", 32'(bus.count), 32'd3);
        check("mid_rst_req_rdy", 32'(bus.echoReq__RDY), 32'd0);
        cyc();
        rst = 1'b0;
        seq_m = 0;
        drive(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("mid_after_count", 32'(bus.count), 32'd0);
        check("mid_after_ind_ena", 32'(bus.ind_echo__ENA), 32'd0);
        cyc();
        @(negedge clk);
        check("mid_idle_ind_ena", 32'(bus.ind_echo__ENA), 32'd0);
        drive(1'b1, 32'h55, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("mid_new_ind_ena", 32'(bus.ind_echo__ENA), 32'd1);
        check("mid_new_v", bus.ind_echo_v, 32'h55);
        check("mid_new_count", 32'(bus.count), 32'd1);
`ifdef ECHO_QUEUE_SEQNUM_EN
        check("mid_new_seq", 32'(bus.ind_echo_seq), seq_m);
`endif
        cyc();
        @(negedge clk);
        check("mid_drained_count", 32'(bus.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/echo_queue.md
ECHO_QUEUE -- requirements
Module: echo_queue

Interface
REQ-001 Parameter WIDTH, default 32, bit width of echoed payload.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, 2..256.
REQ-003 Parameter OFFSET, default 0, constant added to each payload on echo.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 nRST  input  1  reset, synchronous, active-high (1 = reset).
REQ-006 echoReq__ENA  input  1  request strobe; accepted only when echoReq__RDY=1.
REQ-007 echoReq_v  input  WIDTH  request payload.
REQ-008 echoReq__RDY  output  1  queue can accept a request this cycle.
REQ-009 ind_echo__ENA  output  1  indication valid.
REQ-010 ind_echo_v  output  WIDTH  indication payload.
REQ-011 ind_echo__RDY  input  1  consumer accepts indication this cycle.
REQ-012 count  output  log2(DEPTH)+1  current queue occupancy.

Function
REQ-013 Queue SHALL be a circular buffer of DEPTH entries with read/write pointers wrapping modulo DEPTH.
REQ-014 Enqueue SHALL occur when echoReq__ENA=1 and echoReq__RDY=1; echoReq__ENA while echoReq__RDY=0 SHALL be ignored without state change.
REQ-015 echoReq__RDY SHALL equal (count < DEPTH) OR (count = DEPTH AND ind_echo__RDY=1 AND ind_echo__ENA=1).
REQ-016 ind_echo__ENA SHALL equal (count > 0); no combinational path from echoReq__ENA to ind_echo__ENA.
REQ-017 ind_echo_v SHALL equal head entry + OFFSET, truncated to WIDTH bits (mod 2^WIDTH).
REQ-018 Dequeue SHALL occur when ind_echo__ENA=1 and ind_echo__RDY=1.
REQ-019 While ind_echo__ENA=1 and ind_echo__RDY=0, ind_echo_v SHALL hold stable.
REQ-020 Minimum latency: request accepted in cycle N SHALL be presented on ind_echo__ENA in cycle N+1.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged; allowed at full (REQ-015) and at count>=1.
REQ-022 At count=0 a same-cycle request SHALL NOT bypass; indication appears next cycle.
REQ-023 Indications SHALL be delivered in request order, none dropped or duplicated.
REQ-024 count SHALL increment on enqueue-only, decrement on dequeue-only, never exceed DEPTH nor underflow.

Reset
REQ-025 With nRST=1 at a rising edge: pointers=0, count=0, ind_echo__ENA=0, echoReq__RDY=1 on following cycle; storage contents need not clear.
REQ-026 Reset mid-operation SHALL discard all queued entries; requests presented during reset cycle SHALL be dropped.
REQ-027 echoReq__RDY SHALL be 0 while nRST=1.

Configuration
REQ-028 Macro ECHO_QUEUE_SEQNUM_EN: when defined, module SHALL add output ind_echo_seq [15:0], a per-indication sequence number reset to 0, incremented (mod 2^16) on each dequeue, valid with ind_echo__ENA.
REQ-029 Without ECHO_QUEUE_SEQNUM_EN, port ind_echo_seq and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Single echo, OFFSET=0: request 0x0000_1234 at cycle 5, ind_echo__RDY=1 -> ind_echo__ENA=1, ind_echo_v=0x0000_1234 at cycle 6, count back to 0 at cycle 7.
REQ-031 Fill, DEPTH=4, ind_echo__RDY=0: requests 1,2,3,4,5 back-to-back -> first four accepted, count=4, echoReq__RDY=0, 5 not accepted; then ind_echo__RDY=1 -> outputs 1,2,3,4 in order.
REQ-032 Full with concurrent traffic: count=4, ind_echo__RDY=1, request 9 -> echoReq__RDY=1, 9 accepted, count stays 4, 9 emerges after 1..4 drain.
REQ-033 Offset wrap: WIDTH=8, OFFSET=3, request 0xFE -> ind_echo_v=0x01.
REQ-034 Reset mid-stream: count=3, assert nRST one cycle -> count=0, ind_echo__ENA=0 next cycle; queued data never appears.
REQ-035 With ECHO_QUEUE_SEQNUM_EN: 70000 echoes -> ind_echo_seq runs 0..65535, wraps to 0, continues to 4463.
